// File: rtl/deserializer.sv
// Serial-to-parallel receive shifter for the I3C RX datapath. The first bit received lands in bit 0.
// Completed frames are held in a valid/ready output register with odd-parity checking and a sticky overrun flag.
module deserializer #(
  parameter int DATA_W    = 9,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      sample,
  input  logic                      d,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_parity_err,
  output logic                      overrun,
  input  logic                      overrun_clr,
  output logic                      busy,
  output logic [$clog2(DATA_W)-1:0] bit_cnt
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // A T-bit error is flagged when the frame has an even number of ones.
  function automatic logic odd_parity_err(input logic [DATA_W-1:0] word);
    odd_parity_err = PARITY_EN & ~(^word);
  endfunction

  state_t              state_r, next_state_s;
  logic [DATA_W-1:0]   sr_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [DATA_W-1:0]   data_r;
  logic                valid_r;
  logic                perr_r;
  logic                overrun_r;
  logic                busy_s;
  logic                shift_en_s;
  logic                done_s;
  logic                load_s;
  logic [DATA_W-1:0]   word_s;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: abort beats start; start in SHIFT re-arms without leaving SHIFT
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start && !abort) next_state_s = SHIFT;
        else                 next_state_s = IDLE;
      end
      SHIFT: begin
        if (abort) next_state_s = IDLE;
        else       next_state_s = SHIFT;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode: sample strobes that coincide with start/abort are discarded
  always_comb begin
    busy_s     = (state_r == SHIFT);
    shift_en_s = busy_s && sample && !start && !abort;
    done_s     = shift_en_s && (cnt_r == LAST_BIT);
    word_s     = {d, sr_r[DATA_W-1:1]};
    load_s     = done_s && (!valid_r || out_ready);
  end

  // Shift register and bit counter; the counter wraps so back-to-back frames need no re-arm
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_r  <= '0;
      cnt_r <= '0;
    end else if (start || abort) begin
      sr_r  <= '0;
      cnt_r <= '0;
    end else if (shift_en_s) begin
      sr_r  <= word_s;
      cnt_r <= done_s ? '0 : cnt_r + CNT_W'(1);
    end else begin
      sr_r  <= sr_r;
      cnt_r <= cnt_r;
    end
  end

  // Output register; a frame that completes while the held word is still unconsumed is dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r    <= '0;
      valid_r   <= 1'b0;
      perr_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (load_s) begin
        data_r  <= word_s;
        perr_r  <= odd_parity_err(word_s);
        valid_r <= 1'b1;
      end else if (valid_r && out_ready) begin
        valid_r <= 1'b0;
      end
      if (done_s && !load_s) overrun_r <= 1'b1;
      else if (overrun_clr)  overrun_r <= 1'b0;
    end
  end

  assign out_data       = data_r;
  assign out_valid      = valid_r;
  assign out_parity_err = perr_r;
  assign overrun        = overrun_r;
  assign busy           = busy_s;
  assign bit_cnt        = cnt_r;

endmodule
